// File: rtl/mvau_wmem_pkg.sv
// Shared types and helpers for the MVAU weight-stream memory.
package mvau_wmem_pkg;

    // Sequencer states: idle, issuing reads, waiting for the buffer to empty.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Default lane geometry; the top-level parameters normally override these.
    localparam int DEF_SIMD = 2;
    localparam int DEF_TW   = 4;
    localparam int WORD_W   = DEF_SIMD * DEF_TW;

    // Bit offset of lane p inside the packed PE-wide output word.
    function automatic int lane_slice(input int p, input int lane_w);
        return p * lane_w;
    endfunction

endpackage

// File: rtl/mvau_wmem_bank.sv
// One weight bank: simple dual-port RAM, one write port and one registered read port.
module mvau_wmem_bank #(
    parameter int WORD_W  = 8,
    parameter int DEPTH   = 4,
    parameter int ADDR_BW = 2
) (
    input  logic               clk,
    input  logic               wr_en_i,
    input  logic [ADDR_BW-1:0] wr_addr_i,
    input  logic [WORD_W-1:0]  wr_data_i,
    input  logic               rd_en_i,
    input  logic [ADDR_BW-1:0] rd_addr_i,
    output logic [WORD_W-1:0]  rd_data_o
);

    // Contents survive reset; they are reloaded through the write port between layers.
    (* ram_style = "auto" *) logic [WORD_W-1:0] mem_q [DEPTH];

    // Write on the edge; read data is registered and held while no read is issued.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/mvau_weight_stream.sv
// Multi-PE weight memory with address sequencer, streaming PE-wide words over AXI-Stream.
module mvau_weight_stream
    import mvau_wmem_pkg::*;
#(
    parameter int PE           = 2,
    parameter int SIMD         = DEF_SIMD,
    parameter int TW           = DEF_TW,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = $clog2(WMEM_DEPTH),
    parameter int NUM_REPS     = 2,
    parameter int REP_BW       = $clog2(NUM_REPS + 1),
    localparam int PE_BW       = (PE > 1) ? $clog2(PE) : 1,
    localparam int LANE_W      = SIMD * TW,
    localparam int OUT_W       = PE * LANE_W
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    start,
    input  logic                    wr_en,
    input  logic [PE_BW-1:0]        wr_pe,
    input  logic [WMEM_ADDR_BW-1:0] wr_addr,
    input  logic [LANE_W-1:0]       wr_data,
    output logic                    wr_err,
    output logic                    busy,
    output logic                    done,
    output logic [OUT_W-1:0]        m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast
);

    state_t                  state_q;
    logic [WMEM_ADDR_BW-1:0] addr_q;
    logic [REP_BW-1:0]       rep_q;
    logic                    in_flight_q;
    logic                    in_flight_last_q;
    logic                    wr_err_q;

    // Two-entry output buffer; entry 0 is the head driving the stream.
    logic [1:0]              occ_q;
    logic [OUT_W-1:0]        buf_data_q [2];
    logic                    buf_last_q [2];

    logic [OUT_W-1:0]        rd_word;
    logic [2:0]              credit;
    logic                    pop;
    logic                    issue;
    logic                    addr_last;
    logic                    rep_last;
    logic                    wr_pe_ok;
    logic                    wr_accept;
    logic                    last_pop;

    // Credit check counts buffered beats plus the read still in the bank register,
    // so the buffer can never be asked to hold more than two entries.
    always_comb begin
        pop       = (occ_q != 2'd0) && m_axis_tready;
        credit    = {1'b0, occ_q} + {2'b00, in_flight_q};
        issue     = (state_q == RUN) &&
                    ((credit < 3'd2) || ((credit == 3'd2) && pop));
        addr_last = (addr_q == WMEM_ADDR_BW'(WMEM_DEPTH - 1));
        rep_last  = (rep_q == REP_BW'(NUM_REPS - 1));
        wr_pe_ok  = (32'(wr_pe) < 32'(PE));
        wr_accept = wr_en && (state_q == IDLE) && wr_pe_ok;
        last_pop  = (state_q == DRAIN) && pop && (occ_q == 2'd1) && !in_flight_q;
    end

    // One bank per PE; each bank fills its own lane of the read word.
    generate
        for (genvar gi = 0; gi < PE; gi++) begin : g_bank
            localparam int LO = lane_slice(gi, LANE_W);
            mvau_wmem_bank #(
                .WORD_W (LANE_W),
                .DEPTH  (WMEM_DEPTH),
                .ADDR_BW(WMEM_ADDR_BW)
            ) u_bank (
                .clk      (aclk),
                .wr_en_i  (wr_accept && (wr_pe == PE_BW'(gi))),
                .wr_addr_i(wr_addr),
                .wr_data_i(wr_data),
                .rd_en_i  (issue),
                .rd_addr_i(addr_q),
                .rd_data_o(rd_word[LO +: LANE_W])
            );
        end
    endgenerate

    // Sequencer FSM: address/repetition counters, in-flight tracking and write error flag.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            rep_q            <= '0;
            in_flight_q      <= 1'b0;
            in_flight_last_q <= 1'b0;
            wr_err_q         <= 1'b0;
        end else begin
            wr_err_q         <= wr_en && !((state_q == IDLE) && wr_pe_ok);
            in_flight_q      <= issue;
            in_flight_last_q <= addr_last;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        addr_q  <= '0;
                        rep_q   <= '0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (addr_last) begin
                            addr_q <= '0;
                            if (rep_last) begin
                                rep_q   <= '0;
                                state_q <= DRAIN;
                            end else begin
                                rep_q <= rep_q + 1'b1;
                            end
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (last_pop) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output buffer: push the bank word one cycle after its read, pop on handshake.
    always_ff @(posedge aclk) begin
        if (areset) begin
            occ_q         <= 2'd0;
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_last_q[0] <= 1'b0;
            buf_last_q[1] <= 1'b0;
        end else begin
            case ({in_flight_q, pop})
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        buf_data_q[0] <= rd_word;
                        buf_last_q[0] <= in_flight_last_q;
                    end else begin
                        buf_data_q[0] <= buf_data_q[1];
                        buf_last_q[0] <= buf_last_q[1];
                        buf_data_q[1] <= rd_word;
                        buf_last_q[1] <= in_flight_last_q;
                    end
                end
                2'b01: begin
                    buf_data_q[0] <= buf_data_q[1];
                    buf_last_q[0] <= buf_last_q[1];
                    occ_q         <= occ_q - 2'd1;
                end
                2'b10: begin
                    buf_data_q[occ_q[0]] <= rd_word;
                    buf_last_q[occ_q[0]] <= in_flight_last_q;
                    occ_q                <= occ_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign m_axis_tvalid = (occ_q != 2'd0);
    assign m_axis_tdata  = buf_data_q[0];
    assign m_axis_tlast  = buf_last_q[0];
    assign busy          = (state_q != IDLE);
    assign done          = last_pop;
    assign wr_err        = wr_err_q;

endmodule
